// File: rtl/video_pkg.sv
// Shared types and default PET geometry for the video capture path.
package video_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StVskip,
        StHwait,
        StHskip,
        StActive
    } cap_state_e;

    localparam int unsigned PET_H_PIXELS = 320;
    localparam int unsigned PET_V_LINES  = 200;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
module sync2 #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Capture the raw input, then re-register it to settle metastability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/video_capture.sv
// PET video stream receiver: finds the visible window from the active-low syncs and packs
// pixels MSB-first into bytes for a frame buffer.
// Optional line watchdog: define VIDEO_CAPTURE_WATCHDOG_EN.
module video_capture
    import video_pkg::*;
#(
    parameter int unsigned H_PIXELS  = PET_H_PIXELS,
    parameter int unsigned V_LINES   = PET_V_LINES,
    parameter int unsigned H_BACK    = 64,
    parameter int unsigned V_BACK    = 20,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned H_TIMEOUT = 2048
) (
    input  logic              clk16_i,
    input  logic              reset_ni,
    input  logic              pix_en_i,
    input  logic              h_sync_i,
    input  logic              v_sync_i,
    input  logic              video_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              frame_done_o,
    output logic              sync_lost_o
);

    localparam int unsigned PixMax  = (H_PIXELS > H_BACK) ? H_PIXELS : H_BACK;
    localparam int unsigned LineMax = (V_LINES > V_BACK) ? V_LINES : V_BACK;
    localparam int unsigned PixW    = $clog2(PixMax + 1);
    localparam int unsigned LineW   = $clog2(LineMax + 1);

    localparam logic [PixW-1:0]   HBackLast  = PixW'(H_BACK - 1);
    localparam logic [PixW-1:0]   HPixLast   = PixW'(H_PIXELS - 1);
    localparam logic [LineW-1:0]  VBackLast  = LineW'(V_BACK - 1);
    localparam logic [LineW-1:0]  VLinesLast = LineW'(V_LINES - 1);
    localparam logic [ADDR_W-1:0] LineBytes  = ADDR_W'(H_PIXELS / 8);

    logic h_s, v_s, vid_s;
    logic h_prev_q, h_prev_d, v_prev_q, v_prev_d;
    logic h_fall, v_fall;

    cap_state_e        state_q, state_d;
    logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [LineW-1:0]  line_cnt_q, line_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [7:0]        shift_q, shift_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;

    // Syncs idle high, so their synchronizers reset high to avoid a false edge.
    sync2 #(.ResetVal(1'b1)) u_sync_h (
        .clk_i  (clk16_i),
        .rst_ni (reset_ni),
        .d_i    (h_sync_i),
        .q_o    (h_s)
    );

    sync2 #(.ResetVal(1'b1)) u_sync_v (
        .clk_i  (clk16_i),
        .rst_ni (reset_ni),
        .d_i    (v_sync_i),
        .q_o    (v_s)
    );

    sync2 #(.ResetVal(1'b0)) u_sync_vid (
        .clk_i  (clk16_i),
        .rst_ni (reset_ni),
        .d_i    (video_i),
        .q_o    (vid_s)
    );

    // Edges are judged against the level seen at the previous pixel enable.
    always_comb begin
        h_prev_d = pix_en_i ? h_s : h_prev_q;
        v_prev_d = pix_en_i ? v_s : v_prev_q;
        h_fall   = pix_en_i & h_prev_q & ~h_s;
        v_fall   = pix_en_i & v_prev_q & ~v_s;
    end

`ifdef VIDEO_CAPTURE_WATCHDOG_EN
    localparam int unsigned WdW    = $clog2(H_TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(H_TIMEOUT - 1);
    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           sync_lost_q, sync_lost_d;
`endif

    // Capture FSM: window location, pixel packing and byte writes.
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        addr_d       = addr_q;
        line_base_d  = line_base_q;
        shift_d      = shift_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;

        // v_sync takes priority over everything, including a coincident h_sync edge.
        if (v_fall) begin
            state_d     = StVskip;
            pix_cnt_d   = '0;
            line_cnt_d  = '0;
            addr_d      = '0;
            line_base_d = '0;
            shift_d     = '0;
        end else if (pix_en_i) begin
            case (state_q)
                StIdle: ;
                StVskip: begin
                    if (h_fall) begin
                        if (line_cnt_q == VBackLast) begin
                            state_d    = StHwait;
                            line_cnt_d = '0;
                        end else begin
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                    end
                end
                StHwait: begin
                    if (h_fall) begin
                        state_d   = StHskip;
                        pix_cnt_d = '0;
                    end
                end
                StHskip: begin
                    if (pix_cnt_q == HBackLast) begin
                        state_d   = StActive;
                        pix_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
                StActive: begin
                    if (h_fall) begin
                        // Short line: drop the partial byte, realign to the next line slot.
                        shift_d     = '0;
                        pix_cnt_d   = '0;
                        addr_d      = line_base_q + LineBytes;
                        line_base_d = line_base_q + LineBytes;
                        if (line_cnt_q == VLinesLast) begin
                            state_d    = StIdle;
                            line_cnt_d = '0;
                        end else begin
                            state_d    = StHskip;
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                    end else begin
                        shift_d = {shift_q[6:0], vid_s};
                        if (pix_cnt_q[2:0] == 3'd7) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = {shift_q[6:0], vid_s};
                            addr_d    = addr_q + 1'b1;
                        end
                        if (pix_cnt_q == HPixLast) begin
                            pix_cnt_d   = '0;
                            line_base_d = addr_q + 1'b1;
                            if (line_cnt_q == VLinesLast) begin
                                state_d      = StIdle;
                                line_cnt_d   = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                state_d    = StHwait;
                                line_cnt_d = line_cnt_q + 1'b1;
                            end
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

`ifdef VIDEO_CAPTURE_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
        sync_lost_d = sync_lost_q;
        if (v_fall) begin
            wd_cnt_d    = '0;
            sync_lost_d = 1'b0;
        end else if (h_fall) begin
            wd_cnt_d = '0;
        end else if (pix_en_i && (state_q != StIdle)) begin
            if (wd_cnt_q == WdLast) begin
                state_d      = StIdle;
                pix_cnt_d    = '0;
                line_cnt_d   = '0;
                shift_d      = '0;
                wr_en_d      = 1'b0;
                frame_done_d = 1'b0;
                wd_cnt_d     = '0;
                sync_lost_d  = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            h_prev_q     <= 1'b1;
            v_prev_q     <= 1'b1;
            state_q      <= StIdle;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            addr_q       <= '0;
            line_base_q  <= '0;
            shift_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
`ifdef VIDEO_CAPTURE_WATCHDOG_EN
            wd_cnt_q     <= '0;
            sync_lost_q  <= 1'b0;
`endif
        end else begin
            h_prev_q     <= h_prev_d;
            v_prev_q     <= v_prev_d;
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            addr_q       <= addr_d;
            line_base_q  <= line_base_d;
            shift_q      <= shift_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
`ifdef VIDEO_CAPTURE_WATCHDOG_EN
            wd_cnt_q     <= wd_cnt_d;
            sync_lost_q  <= sync_lost_d;
`endif
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign frame_done_o = frame_done_q;

`ifdef VIDEO_CAPTURE_WATCHDOG_EN
    assign sync_lost_o = sync_lost_q;
`else
    // Timeout limit only matters when the watchdog is built.
    logic unused_h_timeout;
    assign unused_h_timeout = ^H_TIMEOUT;
    assign sync_lost_o      = 1'b0;
`endif

endmodule

// File: doc/video_capture.md
# video_capture

Receiver for the PET video stream: samples the active-low horizontal/vertical sync and serial video produced by the video generator (or a real PET main board), locates the visible window, and packs pixels into bytes written to a frame-buffer port. It sits between the video output pins and a dual-port frame buffer read by a VGA/HDMI scan-converter. Edge-aligned, fixed-geometry capture; no PLL or phase tracking.

## Interface
- `H_PIXELS`, 320: visible pixels per line; must be a multiple of 8.
- `V_LINES`, 200: visible lines per frame.
- `H_BACK`, 64: `pix_en_i` cycles skipped after the h_sync falling edge before the first visible pixel.
- `V_BACK`, 20: lines skipped after the v_sync falling edge.
- `ADDR_W`, 13: frame-buffer byte-address width; 2^ADDR_W ≥ H_PIXELS·V_LINES/8.
- `H_TIMEOUT`, 2048: watchdog limit in `pix_en_i` cycles; used only with `VIDEO_CAPTURE_WATCHDOG_EN`.
- `clk16_i` in 1: 16 MHz system clock; the only clock.
- `reset_ni` in 1: asynchronous, active-low reset.
- `pix_en_i` in 1: pixel-rate clock enable, 1-cycle pulse.
- `h_sync_i` in 1: horizontal sync, active low, asynchronous.
- `v_sync_i` in 1: vertical sync, active low, asynchronous.
- `video_i` in 1: serial pixel, 1 = lit, asynchronous.
- `wr_en_o` out 1: frame-buffer write strobe, 1-cycle pulse.
- `wr_addr_o` out ADDR_W: byte address.
- `wr_data_o` out 8: packed pixels; the first pixel is in bit 7.
- `frame_done_o` out 1: 1-cycle pulse when the last byte of a frame is written.
- `sync_lost_o` out 1: sticky; cleared by the next v_sync edge. Tied to 0 without the watchdog.

## Operation
- Each of the three inputs passes through a 2-flop synchronizer clocked every `clk16_i`.
- Edge detect compares the synchronized value with its value at the previous `pix_en_i`. A falling edge is recognised only on `pix_en_i`.
- FSM states: `IDLE`, `VSKIP`, `HWAIT`, `HSKIP`, `ACTIVE`.
  - `IDLE`: v_sync falling edge → `VSKIP`. `line_cnt` = 0, `wr_addr` = 0, `sync_lost` cleared.
  - `VSKIP`: each h_sync falling edge increments `line_cnt`. When `line_cnt` reaches `V_BACK` → `HWAIT`, `line_cnt` = 0.
  - `HWAIT`: h_sync falling edge → `HSKIP`, `pix_cnt` = 0.
  - `HSKIP`: `pix_cnt` counts `pix_en_i`. When it reaches `H_BACK−1` → `ACTIVE`, `pix_cnt` = 0.
  - `ACTIVE`: on each `pix_en_i`, shift `video_i` into the shift register from the LSB side.
    - On every 8th pixel: write the byte and increment the address.
    - After `H_PIXELS` pixels, `line_cnt`+1. If `line_cnt` = `V_LINES` → `IDLE` with `frame_done_o`; otherwise → `HWAIT`.
- v_sync falling edge in any state other than `IDLE`: abort the frame and go to `VSKIP` with counters and address zeroed. No `frame_done_o`; a pending partial byte is discarded.
- h_sync falling edge in `ACTIVE` (short line): discard the partial byte. Address jumps to `line_base + H_PIXELS/8`; `line_cnt`+1; go to `HSKIP` (or `IDLE` if the line limit is reached).
- `wr_addr` is ADDR_W bits; it never wraps within a legal geometry.
- Reset value of every output is 0. Reset mid-frame returns to `IDLE`; no write is issued.

## Timing
- Input to synchronized value: 2 `clk16_i` cycles.
- The edge registers on the next `pix_en_i`.
- `wr_en_o`, `wr_addr_o` and `wr_data_o` are registered and valid together, 1 `clk16_i` after the `pix_en_i` that sampled the 8th pixel of the byte.
  - `wr_addr_o` and `wr_data_o` hold until the next write.
  - No backpressure: the frame buffer must accept a write every cycle.
- `frame_done_o` is asserted in the same cycle as the final `wr_en_o`.
- If a v_sync edge and an h_sync edge coincide, v_sync wins.

## Configuration
- `VIDEO_CAPTURE_WATCHDOG_EN` defined:
  - A counter of `pix_en_i` cycles since the last h_sync edge runs in all states except `IDLE`.
  - Reaching `H_TIMEOUT` → `IDLE` and `sync_lost_o` = 1.
- Not defined:
  - No counter is built.
  - `sync_lost_o` is constant 0.
  - Capture waits for sync edges indefinitely.

## Structure
- Shared package `video_pkg`: capture FSM state enum, default geometry constants (`PET_H_PIXELS`=320, `PET_V_LINES`=200).
- Sub-module `sync2`: 2-flop synchronizer with asynchronous active-low reset; three instances.
- Edge detect, counters, shift register and FSM live in `video_capture`.

## Test plan
- Nominal frame, 320×200, `H_BACK`=64, `V_BACK`=20, alternating 0xAA/0x55 pattern:
  - Exactly 8000 writes, addresses 0–7999.
  - Data matches the pattern.
  - One `frame_done_o`, coincident with the write to address 7999.
- Single lit pixel at visible (x=9, y=3) → one byte with value 0x40 at address 3·40+1=121; all other bytes 0.
- Short line, h_sync after 100 visible pixels on line 5:
  - Line 5 gets 12 writes; the partial byte is dropped.
  - Line 6 starts at address 240.
- v_sync at line 50 of the visible window:
  - No `frame_done_o`.
  - The next frame's first write is to address 0 after 20 skipped lines.
- Watchdog (macro defined, `H_TIMEOUT`=2048), h_sync held high mid-frame:
  - After 2048 `pix_en_i`: `sync_lost_o`=1, no further writes.
  - The next v_sync edge clears it and capture resumes.
- `reset_ni` pulsed mid-`ACTIVE`: all outputs 0 immediately (asynchronous); no writes until a fresh v_sync.
